// File: rtl/rv32_bus_arbiter.sv
// Shares one wait-state memory bus between NUM_PORTS requesters: fixed-priority or round-robin, optional timeout.
// Latency: 3 cycles minimum (IDLE grant, BUSY, RESP pulse); requesters hold valid until port_ready_out, bus stalls via bus_ready_in.
module rv32_bus_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_PORTS-1:0]                  port_valid_in,
    input  logic [NUM_PORTS-1:0]                  port_read_in,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   port_write_mask_in,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       port_address_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       port_write_value_in,
    output logic [NUM_PORTS-1:0]                  port_ready_out,
    output logic [NUM_PORTS-1:0]                  port_error_out,
    output logic [DATA_WIDTH-1:0]                 port_read_value_out,
    output logic                                  bus_valid_out,
    output logic                                  bus_read_out,
    output logic [DATA_WIDTH/8-1:0]               bus_write_mask_out,
    output logic [ADDR_WIDTH-1:0]                 bus_address_out,
    output logic [DATA_WIDTH-1:0]                 bus_write_value_out,
    input  logic                                  bus_ready_in,
    input  logic [DATA_WIDTH-1:0]                 bus_read_value_in
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_read_q, bus_read_d;
    logic [MASK_WIDTH-1:0] bus_mask_q, bus_mask_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]  ready_q, ready_d;
    logic [NUM_PORTS-1:0]  error_q, error_d;

    logic                  gnt_found;
    logic [IDX_W-1:0]      gnt_idx;
    logic [IDX_W-1:0]      cand;
    logic                  sel_read;
    logic [MASK_WIDTH-1:0] sel_mask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  timeout_hit;

    // Round-robin search starts one past the last grant and wraps.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ARB_MODE == 0) begin
                cand = IDX_W'(i);
            end else begin
                cand = IDX_W'((int'(rr_ptr_q) + 1 + i) % NUM_PORTS);
            end
            if (!gnt_found && port_valid_in[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_read  = 1'b0;
        sel_mask  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_idx == IDX_W'(p)) begin
                sel_read  = port_read_in[p];
                sel_mask  = port_write_mask_in[p*MASK_WIDTH +: MASK_WIDTH];
                sel_addr  = port_address_in[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = port_write_value_in[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt_q == CNT_W'(TO_LAST));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        bus_valid_d = bus_valid_q;
        bus_read_d  = bus_read_q;
        bus_mask_d  = bus_mask_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = '0;
        ready_d     = '0;
        error_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d     = S_BUSY;
                    grant_d     = gnt_idx;
                    rr_ptr_d    = gnt_idx;
                    wait_cnt_d  = '0;
                    bus_valid_d = 1'b1;
                    bus_read_d  = sel_read;
                    bus_mask_d  = sel_read ? '0 : sel_mask;
                    bus_addr_d  = sel_addr;
                    bus_wdata_d = sel_wdata;
                end
            end
            S_BUSY: begin
                // A ready in the final allowed cycle beats the timeout.
                if (bus_ready_in) begin
                    state_d          = S_RESP;
                    bus_valid_d      = 1'b0;
                    bus_read_d       = 1'b0;
                    bus_mask_d       = '0;
                    rdata_d          = bus_read_q ? bus_read_value_in : '0;
                    ready_d[grant_q] = 1'b1;
                end else if (timeout_hit) begin
                    state_d          = S_RESP;
                    bus_valid_d      = 1'b0;
                    bus_read_d       = 1'b0;
                    bus_mask_d       = '0;
                    ready_d[grant_q] = 1'b1;
                    error_d[grant_q] = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= IDX_W'(NUM_PORTS - 1);
            wait_cnt_q  <= '0;
            bus_valid_q <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_mask_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            ready_q     <= '0;
            error_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_read_q  <= bus_read_d;
            bus_mask_q  <= bus_mask_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign port_ready_out      = ready_q;
    assign port_error_out      = error_q;
    assign port_read_value_out = rdata_q;
    assign bus_valid_out       = bus_valid_q;
    assign bus_read_out        = bus_read_q;
    assign bus_write_mask_out  = bus_mask_q;
    assign bus_address_out     = bus_addr_q;
    assign bus_write_value_out = bus_wdata_q;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Scoreboard bench: random requesters and a random-wait bus against a round-robin/timeout reference model,
// plus a fixed-priority instance with a zero-wait bus for grant order and throughput.
module tb_rv32_bus_arbiter;
    localparam int NP = 3;
    localparam int T  = 4;

    logic          clk;
    logic          reset_n;
    logic [NP-1:0] port_valid_in, port_read_in;
    logic [NP*4-1:0]  port_write_mask_in;
    logic [NP*32-1:0] port_address_in, port_write_value_in;
    logic [NP-1:0] port_ready_out, port_error_out;
    logic [31:0]   port_read_value_out;
    logic          bus_valid_out, bus_read_out;
    logic [3:0]    bus_write_mask_out;
    logic [31:0]   bus_address_out, bus_write_value_out;
    logic          bus_ready_in;
    logic [31:0]   bus_read_value_in;

    logic [1:0]  fp_valid;
    logic [1:0]  fp_ready, fp_err;
    logic [31:0] fp_rdata, fp_bus_addr, fp_bus_wdata;
    logic        fp_bus_valid, fp_bus_read;
    logic [3:0]  fp_bus_mask;

    rv32_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .port_valid_in(port_valid_in), .port_read_in(port_read_in),
        .port_write_mask_in(port_write_mask_in), .port_address_in(port_address_in),
        .port_write_value_in(port_write_value_in),
        .port_ready_out(port_ready_out), .port_error_out(port_error_out),
        .port_read_value_out(port_read_value_out),
        .bus_valid_out(bus_valid_out), .bus_read_out(bus_read_out),
        .bus_write_mask_out(bus_write_mask_out), .bus_address_out(bus_address_out),
        .bus_write_value_out(bus_write_value_out),
        .bus_ready_in(bus_ready_in), .bus_read_value_in(bus_read_value_in)
    );

    rv32_bus_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT_CYCLES(0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .port_valid_in(fp_valid), .port_read_in(2'b11),
        .port_write_mask_in(8'h00), .port_address_in({32'h0000_0080, 32'h0000_0040}),
        .port_write_value_in(64'h0),
        .port_ready_out(fp_ready), .port_error_out(fp_err),
        .port_read_value_out(fp_rdata),
        .bus_valid_out(fp_bus_valid), .bus_read_out(fp_bus_read),
        .bus_write_mask_out(fp_bus_mask), .bus_address_out(fp_bus_addr),
        .bus_write_value_out(fp_bus_wdata),
        .bus_ready_in(fp_bus_valid), .bus_read_value_in(fp_bus_addr ^ 32'hA5A5_0000)
    );

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    logic stall_bus = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired or illegal event (cycle %0d)", name, cyc);
    endtask

    // Reference arbitration: first requesting port after the last grant, wrapping.
    function automatic int model_grant(input logic [NP-1:0] v, input int last);
        for (int i = 1; i <= NP; i++) begin
            int c = (last + i) % NP;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Bus responder and reference model: predicts the grant and the response for each access.
    logic [NP-1:0] vld_prev;
    logic          bv_prev;
    logic          active;
    int            rr_m, g, w, k;
    logic [31:0]   rdv, exp_addr;
    initial begin
        bus_ready_in = 1'b0; bus_read_value_in = '0;
        vld_prev = '0; bv_prev = 1'b0; active = 1'b0; rr_m = NP - 1;
        g = 0; w = 0; k = 0; rdv = '0; exp_addr = '0;
        forever begin
            @(negedge clk);
            bus_ready_in      = 1'b0;
            bus_read_value_in = $urandom;
            if (!reset_n) begin
                active = 1'b0; bv_prev = 1'b0; rr_m = NP - 1; vld_prev = port_valid_in;
                continue;
            end
            if (bus_valid_out && !bv_prev) begin
                g = model_grant(vld_prev, rr_m);
                if (g < 0) begin
                    fail_now("grant_without_request");
                end else begin
                    rr_m     = g;
                    exp_addr = port_address_in[g*32 +: 32];
                    check("bus_addr", bus_address_out, exp_addr);
                    check("bus_read", 32'(bus_read_out), 32'(port_read_in[g]));
                    check("bus_mask", 32'(bus_write_mask_out),
                          port_read_in[g] ? 32'h0 : 32'(port_write_mask_in[g*4 +: 4]));
                    if (!port_read_in[g])
                        check("bus_wdata", bus_write_value_out, port_write_value_in[g*32 +: 32]);
                    w   = stall_bus ? 5 : int'($urandom_range(0, 5));
                    rdv = $urandom;
                    exp_q.push_back('{port: g, err: (w >= T),
                                      data: (w >= T || !port_read_in[g]) ? 32'h0 : rdv,
                                      due: cyc + ((w >= T) ? T - 1 : w) + 1});
                    active = 1'b1;
                    k      = 0;
                end
            end
            if (active) begin
                if (!bus_valid_out) begin
                    check("timeout_valid_len", 32'(k), 32'(T));
                    active = 1'b0;
                end else begin
                    check("bus_addr_hold", bus_address_out, exp_addr);
                    if (k == w) begin
                        bus_ready_in      = 1'b1;
                        bus_read_value_in = rdv;
                        active            = 1'b0;
                    end
                    k++;
                end
            end
            bv_prev  = bus_valid_out;
            vld_prev = port_valid_in;
        end
    end

    // Response monitor: every pulse must match the oldest predicted response, in the predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && (port_ready_out != '0 || port_error_out != '0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'(port_ready_out), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_ready", 32'(port_ready_out), 32'(1) << e.port);
                    check("resp_error", 32'(port_error_out), e.err ? (32'(1) << e.port) : 32'h0);
                    check("resp_data", port_read_value_out, e.data);
                    check("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Fixed-priority instance: port 0 always wins, one access every 3 cycles.
    int fp_cnt = 0;
    int fp_last = -1;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && fp_bus_valid) begin
                check("fp_bus_read", 32'(fp_bus_read), 32'h1);
                check("fp_bus_mask", 32'(fp_bus_mask), 32'h0);
                check("fp_bus_wdata", fp_bus_wdata, 32'h0);
            end
            if (reset_n && (fp_ready != 2'b00 || fp_err != 2'b00)) begin
                check("fp_grant", 32'(fp_ready), 32'h1);
                check("fp_error", 32'(fp_err), 32'h0);
                check("fp_data", fp_rdata, 32'hA5A5_0040);
                if (fp_last >= 0) check("fp_gap", 32'(cyc - fp_last), 32'h3);
                fp_last = cyc;
                fp_cnt++;
            end
        end
    end

    task automatic issue(input int p);
        logic [31:0] r;
        logic [1:0]  pb;
        r  = $urandom;
        pb = 2'(p);
        port_read_in[p]                = r[0];
        port_address_in[p*32 +: 32]    = {r[31:4], pb, 2'b00};
        port_write_value_in[p*32 +: 32] = $urandom;
        port_write_mask_in[p*4 +: 4]   = 4'($urandom_range(1, 15));
        port_valid_in[p]               = 1'b1;
    endtask

    task automatic run_random(input int n);
        int remaining[NP];
        int gap[NP];
        int age[NP];
        logic [NP-1:0] rdy;
        int guard = 0;
        for (int p = 0; p < NP; p++) begin
            remaining[p] = n; gap[p] = int'($urandom_range(0, 3)); age[p] = 0;
        end
        while ((remaining[0] + remaining[1] + remaining[2]) > 0 && guard < 20000) begin
            guard++;
            @(negedge clk);
            rdy = port_ready_out;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (port_valid_in[p]) begin
                    age[p]++;
                    if (rdy[p]) begin
                        port_valid_in[p] = 1'b0; remaining[p]--; gap[p] = int'($urandom_range(0, 3));
                    end else if (age[p] > 100) begin
                        fail_now("request_never_ready");
                        port_valid_in[p] = 1'b0; remaining[p]--;
                    end
                end
                if (!port_valid_in[p] && remaining[p] > 0) begin
                    if (gap[p] == 0) begin
                        issue(p); age[p] = 0;
                    end else begin
                        gap[p]--;
                    end
                end
            end
        end
        if (guard >= 20000) fail_now("random_phase_budget");
    endtask

    initial begin
        int i;
        reset_n = 1'b0;
        port_valid_in = '0; port_read_in = '0; port_write_mask_in = '0;
        port_address_in = '0; port_write_value_in = '0; fp_valid = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_valid", 32'(bus_valid_out), 32'h0);
        check("rst_ready", 32'(port_ready_out), 32'h0);
        check("rst_error", 32'(port_error_out), 32'h0);
        check("rst_rdata", port_read_value_out, 32'h0);
        check("rst_bus_addr", bus_address_out, 32'h0);
        check("rst_bus_mask", 32'(bus_write_mask_out), 32'h0);
        reset_n = 1'b1;

        run_random(25);
        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        @(posedge clk); #1 fp_valid = 2'b11;
        repeat (40) @(posedge clk);
        #1 fp_valid = 2'b00;
        repeat (8) @(negedge clk);
        check("fp_access_count", 32'(fp_cnt), 32'd14);

        // Reset in the middle of a stalled access: nothing may be pulsed.
        stall_bus = 1'b1;
        @(posedge clk); #1;
        port_read_in[0] = 1'b1; port_address_in[31:0] = 32'h0000_0040; port_valid_in[0] = 1'b1;
        i = 0;
        while (i < 20 && !bus_valid_out) begin
            @(negedge clk); i++;
        end
        check("rst_test_bus_valid", 32'(bus_valid_out), 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_bus_valid", 32'(bus_valid_out), 32'h0);
        check("async_rst_ready", 32'(port_ready_out), 32'h0);
        check("async_rst_error", 32'(port_error_out), 32'h0);
        port_valid_in[0] = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        stall_bus = 1'b0;
        reset_n   = 1'b1;

        run_random(4);
        repeat (10) @(negedge clk);
        check("final_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
